// File: rtl/mult_reg_sequencer_pkg.sv
// Shared definitions for the Thumb multi-register transfer sequencer:
// register numbers, opcode constants and the sequencer state type.
package mult_reg_sequencer_pkg;

  localparam int unsigned GEN_ADDR_WIDTH = 4;
  localparam int unsigned SP_REG_NUM     = 13;
  localparam int unsigned LR_REG_NUM     = 14;
  localparam int unsigned PC_REG_NUM     = 15;

  localparam logic [6:0] OP_PUSH = 7'b1011010;
  localparam logic [6:0] OP_POP  = 7'b1011110;
  localparam logic [4:0] OP_STM  = 5'b11000;
  localparam logic [4:0] OP_LDM  = 5'b11001;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB
  } seq_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/mult_reg_sequencer_lsb_priority_enc.sv
// Lowest-set-bit encoder over a 16-bit register list; combinational.
module lsb_priority_enc (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    // Scan from the top so the lowest set bit wins last.
    for (int unsigned i = 16; i > 0; i--) begin
      if (vec_i[i-1]) begin
        idx_o = 4'(i - 1);
      end
    end
  end

endmodule

// File: rtl/mult_reg_sequencer.sv
// Expands PUSH/POP/STM/LDM into one registered micro-op per register,
// followed by an optional base-writeback micro-op.
module mult_reg_sequencer
  import mult_reg_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GEN_ADDR_WIDTH,
  parameter int unsigned OFF_WIDTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [15:0]                 instruction_i,
  input  logic                        stall_i,
  output logic                        ready_o,
  output logic                        busy_o,
  output logic                        uop_valid_o,
  output logic                        uop_is_load_o,
  output logic                        uop_wb_o,
  output logic [ADDR_WIDTH-1:0]       uop_data_reg_o,
  output logic [ADDR_WIDTH-1:0]       uop_base_reg_o,
  output logic signed [OFF_WIDTH-1:0] uop_offset_o
);

  seq_state_t                   state_q, state_d;
  logic [15:0]                  list_q, list_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic [ADDR_WIDTH-1:0]        data_q, data_d;
  logic                         load_q, load_d;
  logic                         wb_q, wb_d;
  logic                         wbreq_q, wbreq_d;
  logic signed [OFF_WIDTH-1:0]  off_q, off_d;
  logic signed [OFF_WIDTH-1:0]  wboff_q, wboff_d;

  logic [15:0]                  dec_list;
  logic                         dec_match, dec_push, dec_load, dec_wb;
  logic [ADDR_WIDTH-1:0]        dec_base;
  logic signed [OFF_WIDTH-1:0]  four_n;

  logic [15:0]                  enc_in;
  logic [3:0]                   enc_idx;
  logic                         enc_valid;

  always_comb begin
    dec_list  = '0;
    dec_match = 1'b0;
    dec_push  = 1'b0;
    dec_load  = 1'b0;
    dec_wb    = 1'b0;
    dec_base  = '0;
    if (instruction_i[15:9] == OP_PUSH) begin
      dec_match = 1'b1;
      dec_push  = 1'b1;
      dec_wb    = 1'b1;
      dec_base  = ADDR_WIDTH'(SP_REG_NUM);
      dec_list  = {1'b0, instruction_i[8], 6'b0, instruction_i[7:0]};
    end else if (instruction_i[15:9] == OP_POP) begin
      dec_match = 1'b1;
      dec_load  = 1'b1;
      dec_wb    = 1'b1;
      dec_base  = ADDR_WIDTH'(SP_REG_NUM);
      dec_list  = {instruction_i[8], 7'b0, instruction_i[7:0]};
    end else if (instruction_i[15:11] == OP_STM) begin
      dec_match = 1'b1;
      dec_wb    = 1'b1;
      dec_base  = ADDR_WIDTH'(instruction_i[10:8]);
      dec_list  = {8'b0, instruction_i[7:0]};
    end else if (instruction_i[15:11] == OP_LDM) begin
      dec_match = 1'b1;
      dec_load  = 1'b1;
      // A loaded base overrides writeback.
      dec_wb    = ~instruction_i[instruction_i[10:8]];
      dec_base  = ADDR_WIDTH'(instruction_i[10:8]);
      dec_list  = {8'b0, instruction_i[7:0]};
    end
    four_n = OFF_WIDTH'({popcount16(dec_list), 2'b00});
  end

  // One encoder serves both the initial pick and the remaining-list scan.
  assign enc_in = (state_q == IDLE) ? dec_list : list_q;

  lsb_priority_enc u_enc (
    .vec_i   (enc_in),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    base_d  = base_q;
    data_d  = data_q;
    load_d  = load_q;
    wb_d    = wb_q;
    wbreq_d = wbreq_q;
    off_d   = off_q;
    wboff_d = wboff_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && dec_match && enc_valid) begin
          state_d = XFER;
          list_d  = dec_list & ~(16'b1 << enc_idx);
          data_d  = ADDR_WIDTH'(enc_idx);
          base_d  = dec_base;
          load_d  = dec_load;
          wb_d    = 1'b0;
          wbreq_d = dec_wb;
          off_d   = dec_push ? -four_n : '0;
          wboff_d = dec_push ? -four_n : four_n;
        end
      end
      XFER: begin
        if (!stall_i) begin
          if (enc_valid) begin
            list_d = list_q & ~(16'b1 << enc_idx);
            data_d = ADDR_WIDTH'(enc_idx);
            off_d  = off_q + OFF_WIDTH'(4);
          end else if (wbreq_q) begin
            state_d = WB;
            data_d  = base_q;
            off_d   = wboff_q;
            wb_d    = 1'b1;
            load_d  = 1'b0;
          end else begin
            state_d = IDLE;
            {list_d, base_d, data_d, load_d, wb_d, wbreq_d} = '0;
            {off_d, wboff_d} = '0;
          end
        end
      end
      WB: begin
        if (!stall_i) begin
          state_d = IDLE;
          {list_d, base_d, data_d, load_d, wb_d, wbreq_d} = '0;
          {off_d, wboff_d} = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      list_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      wbreq_q <= 1'b0;
      off_q   <= '0;
      wboff_q <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      base_q  <= base_d;
      data_q  <= data_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      wbreq_q <= wbreq_d;
      off_q   <= off_d;
      wboff_q <= wboff_d;
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign uop_valid_o    = busy_o;
  assign uop_is_load_o  = load_q;
  assign uop_wb_o       = wb_q;
  assign uop_data_reg_o = data_q;
  assign uop_base_reg_o = base_q;
  assign uop_offset_o   = off_q;

endmodule

// File: doc/mult_reg_sequencer.md
# mult_reg_sequencer

Expands a Thumb multi-register transfer into one micro-op per register: PUSH, POP, STM and LDM. It sits between decode and execute. While it runs it stalls fetch/decode and feeds the register file and load/store unit a stream of single transfers, followed by an optional base-writeback micro-op. It supplies the register addresses that the single-instruction address decoder reports only as SP or Rn for these opcodes.

## Interface
- Parameters:
- `ADDR_WIDTH`, default 4: register address width. Taken from the shared defs.
- `OFF_WIDTH`, default 8: signed byte-offset width. Covers -36..+36.
- Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. Asynchronous, active-high.
- `start_i` input 1: decode presents `instruction_i` this cycle.
- `instruction_i` input 16: Thumb halfword.
- `stall_i` input 1: downstream stall. Holds the current micro-op.
- `ready_o` output 1: sequencer idle. A start is accepted only when this is high.
- `busy_o` output 1: sequence in progress. Decode/fetch must stall.
- `uop_valid_o` output 1: micro-op outputs valid.
- `uop_is_load_o` output 1: 1 = load, 0 = store. Ignored when `uop_wb_o` is high.
- `uop_wb_o` output 1: base-writeback micro-op. Computes base := base + offset.
- `uop_data_reg_o` output `ADDR_WIDTH`: register being loaded or stored.
- `uop_base_reg_o` output `ADDR_WIDTH`: base register (SP or Rn).
- `uop_offset_o` output signed `OFF_WIDTH`: byte offset applied to the original base value.

## Operation
- Decode of `instruction_i` while `start_i & ready_o`:
- PUSH, `[15:9]=1011010`: list = {M→r14, [7:0]}; store; base SP; writeback always.
- POP, `[15:9]=1011110`: list = {P→r15, [7:0]}; load; base SP; writeback always.
- STM, `[15:11]=11000`: list `[7:0]`; store; base Rn=`[10:8]`; writeback always.
- LDM, `[15:11]=11001`: list `[7:0]`; load; base Rn; writeback only if the Rn bit is clear in the list.
- Any other opcode: ignored. The block stays in IDLE and emits no micro-op.
- Empty list: ignored, same as a non-matching opcode.
- Count and offsets:
- N = popcount of the 16-bit list, 1..9.
- Start offset is −4N for PUSH and 0 otherwise.
- Writeback offset is −4N for PUSH and +4N otherwise.
- Transfer order: ascending register number. The lowest set bit is taken via the priority encoder and then cleared.
- Each transfer's offset = start offset + 4·k, where k is the transfer index from 0. So r15 on POP is always the last transfer.
- All offsets are relative to the base value read at the first micro-op. Execute holds that value; the base register is not updated until the WB micro-op.
- State machine:
- IDLE: `ready_o`=1, `busy_o`=0. On an accepted, valid multi-register instruction, go to XFER.
- XFER: one transfer is presented. On each cycle with `stall_i`=0 the block advances to the next register. After the last register it goes to WB if writeback is required, otherwise to IDLE.
- WB: presents `uop_wb_o`=1 with data_reg = base. On a cycle with `stall_i`=0 it goes to IDLE.
- `busy_o` = (state ≠ IDLE). `uop_valid_o` = `busy_o`.
- `stall_i` high: every `uop_*` output and all internal state are held unchanged.
- `start_i` while busy: ignored. Decode is stalled by `busy_o`, so decode holds the instruction.

## Timing
- Reset values: state IDLE, `ready_o`=1, `busy_o`=0, and all other outputs 0.
- `rst_i` asserted mid-sequence returns the block to IDLE immediately, with no partial writeback. Squashing the partial transfers is handled outside this block.
- The instruction is accepted on the edge where `start_i & ready_o` is high. The first micro-op is registered and valid the following cycle.
- With no stalls, a sequence occupies N cycles plus 1 if there is a writeback. `ready_o` rises in the cycle after the final micro-op is consumed.
- No back-to-back overlap: there is at least one IDLE cycle between sequences.
- All `uop_*` outputs are registered. There is no combinational path from `instruction_i` to any output.

## Structure
- Shared defs (GENERAL_DEFS.svh) hold:
- `ADDR_WIDTH`, `SP_REG_NUM`=13, `LR_REG_NUM`=14, `PC_REG_NUM`=15;
- the PUSH/POP/STM/LDM opcode constants;
- a `seq_state_t` enum {IDLE, XFER, WB}.
- Sub-module `lsb_priority_enc`: 16-bit one-hot/lowest-set-bit encoder that returns the 4-bit index plus a valid flag. It is combinational and used for the remaining-list scan.
- Registered state: state, remaining list, base reg, load flag, wb-required flag, current offset, N.

## Test plan
- PUSH {r0,r2,lr} `0xB505` → stores r0/−12, r2/−8, r14/−4 with base 13, then WB base 13 off −12; 4 micro-op cycles.
- POP {r1,pc} `0xBD02` → loads r1/0, r15/+4, then WB r13 +8; r15 is last before WB.
- LDM r2!,{r1,r2} `0xCA06` → loads r1/0 and r2/+4 from base 2; no WB; `ready_o` back after 2 micro-op cycles.
- STM r3!,{r0} `0xC301` with `stall_i` high for 3 cycles on the first micro-op → r0/0 held stable for those 3 cycles, then WB r3 +4.
- Non-multi instruction `0x1888` with `start_i` → no `uop_valid_o`, `ready_o` stays 1. `start_i` pulsed mid-sequence → ignored.
- `rst_i` asserted during the second transfer of `0xB505` → all outputs zero and `ready_o`=1 asynchronously. A fresh `0xBD02` afterwards then sequences correctly.
